// File: rtl/ysyx_22041071_div_sched_if.sv
// Handshake bundle between EX, the divide sequencer and the shared iterative divider.
interface ysyx_22041071_div_sched_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            req_valid;
  logic [1:0]      req_op;
  logic            req_w;
  logic [XLEN-1:0] req_src1;
  logic [XLEN-1:0] req_src2;
  logic            stall;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic            div_valid;
  logic            div_signed;
  logic            divw;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic            div_flush;
  logic            div_ready;
  logic            div_out_valid;
  logic [XLEN-1:0] div_quot;
  logic [XLEN-1:0] div_rema;

  modport slave (
    input  flush, req_valid, req_op, req_w, req_src1, req_src2,
           div_ready, div_out_valid, div_quot, div_rema,
    output stall, resp_valid, resp_data,
           div_valid, div_signed, divw, div_dividend, div_divisor, div_flush
  );

  modport master (
    output flush, req_valid, req_op, req_w, req_src1, req_src2,
           div_ready, div_out_valid, div_quot, div_rema,
    input  stall, resp_valid, resp_data,
           div_valid, div_signed, divw, div_dividend, div_divisor, div_flush
  );
endinterface

// File: rtl/ysyx_22041071_div_sched.sv
// Divide/remainder sequencer: resolves divide-by-zero and signed overflow locally,
// otherwise drives the shared divider and formats its quotient/remainder.
module ysyx_22041071_div_sched #(
  parameter int XLEN = 64
) (
  input logic                       clk,
  input logic                       reset,
  ysyx_22041071_div_sched_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic            signed_q, signed_d;
  logic            divw_q, divw_d;
  logic            sel_rem_q, sel_rem_d;
  logic            w_q, w_d;

  logic            div_zero, ovf, special;
  logic [XLEN-1:0] src1_w_sext, special_res;
  logic [XLEN-1:0] div_res, div_res_fmt;

  always_comb begin
    src1_w_sext = {{(XLEN-32){bus.req_src1[31]}}, bus.req_src1[31:0]};
    div_zero    = bus.req_w ? (bus.req_src2[31:0] == '0) : (bus.req_src2 == '0);
    ovf         = ~bus.req_op[0] &
                  (bus.req_w ? ((bus.req_src1[31:0] == 32'h8000_0000) && (bus.req_src2[31:0] == '1))
                             : ((bus.req_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.req_src2 == '1)));
    special     = div_zero | ovf;
    special_res = '0;
    if (div_zero)
      special_res = bus.req_op[1] ? (bus.req_w ? src1_w_sext : bus.req_src1) : '1;
    else if (ovf)
      special_res = bus.req_op[1] ? '0 : (bus.req_w ? src1_w_sext : bus.req_src1);
  end

  always_comb begin
    div_res     = sel_rem_q ? bus.div_rema : bus.div_quot;
    div_res_fmt = w_q ? {{(XLEN-32){div_res[31]}}, div_res[31:0]} : div_res;
  end

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    resp_data_d = resp_data_q;
    signed_d    = signed_q;
    divw_d      = divw_q;
    sel_rem_d   = sel_rem_q;
    w_d         = w_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          if (special) begin
            resp_data_d = special_res;
            state_d     = S_RESP;
          end else if (bus.div_ready) begin
            dividend_d = bus.req_src1;
            divisor_d  = bus.req_src2;
            signed_d   = ~bus.req_op[0];
            divw_d     = bus.req_w;
            sel_rem_d  = bus.req_op[1];
            w_d        = bus.req_w;
            state_d    = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        // A flush coinciding with the done pulse skips DRAIN: the divider is already idling.
        if (bus.flush) begin
          state_d = bus.div_out_valid ? S_IDLE : S_DRAIN;
        end else if (bus.div_out_valid) begin
          resp_data_d = div_res_fmt;
          state_d     = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_DRAIN: if (bus.div_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      resp_data_q <= '0;
      signed_q    <= 1'b0;
      divw_q      <= 1'b0;
      sel_rem_q   <= 1'b0;
      w_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      resp_data_q <= resp_data_d;
      signed_q    <= signed_d;
      divw_q      <= divw_d;
      sel_rem_q   <= sel_rem_d;
      w_q         <= w_d;
    end
  end

  assign bus.resp_valid   = (state_q == S_RESP) & ~bus.flush;
  assign bus.resp_data    = resp_data_q;
  assign bus.stall        = bus.req_valid & ~((state_q == S_RESP) & ~bus.flush);
  assign bus.div_valid    = (state_q == S_BUSY) & ~bus.flush;
  assign bus.div_signed   = signed_q;
  assign bus.divw         = divw_q;
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign bus.div_flush    = bus.flush;

endmodule

// File: tb/tb_ysyx_22041071_div_sched.sv
// Directed bench for the divide sequencer with a variable-latency divider model.
module tb_ysyx_22041071_div_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ysyx_22041071_div_sched_if #(.XLEN(64)) bus ();
  ysyx_22041071_div_sched #(.XLEN(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Divider model: latency m_lat, abort recovery m_drain cycles, W results carry junk upper bits.
  int          m_lat = 6;
  int          m_drain = 4;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  int          m_abort = 0;
  logic [63:0] m_a, m_b;
  logic        m_sgn, m_w;

  assign bus.div_ready = !m_busy && (m_abort == 0) && !bus.div_out_valid;

  function automatic logic [127:0] div_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic sgn, input logic w);
    logic [63:0] q, r;
    logic signed [63:0] sa, sb;
    logic [31:0] a32, b32, q32, r32;
    logic signed [31:0] sa32, sb32;
    if (w) begin
      a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
      if (sgn) begin q32 = sa32 / sb32; r32 = sa32 % sb32; end
      else     begin q32 = a32 / b32;   r32 = a32 % b32;   end
      q = {32'hDEAD_BEEF, q32};
      r = {32'hDEAD_BEEF, r32};
    end else begin
      sa = a; sb = b;
      if (sgn) begin q = sa / sb; r = sa % sb; end
      else     begin q = a / b;   r = a % b;   end
    end
    return {q, r};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy            <= 1'b0;
      m_abort           <= 0;
      bus.div_out_valid <= 1'b0;
      bus.div_quot      <= '0;
      bus.div_rema      <= '0;
    end else begin
      bus.div_out_valid <= 1'b0;
      if (m_abort > 0) m_abort <= m_abort - 1;
      else if (m_busy) begin
        if (bus.div_flush) begin
          m_busy  <= 1'b0;
          m_abort <= m_drain;
        end else if (m_cnt <= 1) begin
          m_busy            <= 1'b0;
          bus.div_out_valid <= 1'b1;
          {bus.div_quot, bus.div_rema} <= div_model(m_a, m_b, m_sgn, m_w);
        end else m_cnt <= m_cnt - 1;
      end else if (bus.div_valid && bus.div_ready) begin
        m_busy <= 1'b1;
        m_cnt  <= m_lat;
        m_a    <= bus.div_dividend;
        m_b    <= bus.div_divisor;
        m_sgn  <= bus.div_signed;
        m_w    <= bus.divw;
      end
    end
  end

  // Presents one request (entered at a negedge) and observes until the response strobe.
  task automatic run_req(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] data, output int rc,
                         output int ov, output bit saw_dv, output bit stall_ok);
    data = '0; rc = -1; ov = -1; saw_dv = 1'b0; stall_ok = 1'b1;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_w = w;
    bus.req_src1 = a; bus.req_src2 = b;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (bus.div_valid) saw_dv = 1'b1;
      if (bus.resp_valid) begin
        data = bus.resp_data;
        rc = c;
        if (bus.stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
      if (bus.div_out_valid) ov = c;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if ({bus.stall, bus.resp_valid, bus.div_valid, bus.div_signed, bus.divw} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000", {bus.stall, bus.resp_valid, bus.div_valid, bus.div_signed, bus.divw}); end
    n_cmp++; if (bus.resp_data !== 64'h0) begin
      n_err++; $display("FAIL reset_resp_data: got %h want 0", bus.resp_data); end
    n_cmp++; if ({bus.div_dividend, bus.div_divisor} !== 128'h0) begin
      n_err++; $display("FAIL reset_operands: got %h %h want 0 0", bus.div_dividend, bus.div_divisor); end
    n_cmp++; if (bus.div_flush !== 1'b0) begin
      n_err++; $display("FAIL reset_div_flush0: got %b want 0", bus.div_flush); end
    bus.flush = 1'b1; #1;
    n_cmp++; if (bus.div_flush !== 1'b1) begin
      n_err++; $display("FAIL reset_div_flush1: got %b want 1", bus.div_flush); end
    bus.flush = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_div_signed;
    logic [63:0] d; int rc, ov; bit dv, sok;
    run_req(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, d, rc, ov, dv, sok);
    n_cmp++; if (d !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_err++; $display("FAIL div_neg7_2: got %h want fffffffffffffffd", d); end
    n_cmp++; if (ov < 0 || rc != ov + 1) begin
      n_err++; $display("FAIL div_latency: got resp@%0d done@%0d want resp=done+1", rc, ov); end
    n_cmp++; if (!sok) begin
      n_err++; $display("FAIL div_stall: got stall profile bad want high until RESP then low"); end
    n_cmp++; if (!dv) begin
      n_err++; $display("FAIL div_issued: got div_valid never want asserted"); end
  endtask

  task automatic test_w_forms;
    logic [63:0] d; int rc, ov; bit dv, sok;
    run_req(2'b11, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd10, d, rc, ov, dv, sok);
    n_cmp++; if (d !== 64'd5) begin
      n_err++; $display("FAIL remuw: got %h want 5", d); end
    run_req(2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, d, rc, ov, dv, sok);
    n_cmp++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++; $display("FAIL remw: got %h want ffffffffffffffff", d); end
    n_cmp++; if (rc != ov + 1 || !sok) begin
      n_err++; $display("FAIL remw_timing: got resp@%0d done@%0d stall_ok=%0b want done+1, 1", rc, ov, sok); end
  endtask

  task automatic test_div_zero;
    logic [63:0] d; int rc, ov; bit dv, sok;
    run_req(2'b01, 1'b0, 64'd77, 64'd0, d, rc, ov, dv, sok);
    n_cmp++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF || rc != 1) begin
      n_err++; $display("FAIL divu_zero: got %h @%0d want ffffffffffffffff @1", d, rc); end
    n_cmp++; if (dv) begin
      n_err++; $display("FAIL divu_zero_nodiv: got div_valid=1 want 0"); end
    run_req(2'b10, 1'b0, 64'h1234, 64'd0, d, rc, ov, dv, sok);
    n_cmp++; if (d !== 64'h1234 || rc != 1 || dv) begin
      n_err++; $display("FAIL rem_zero: got %h @%0d dv=%0b want 1234 @1 dv=0", d, rc, dv); end
    run_req(2'b01, 1'b1, 64'd5, 64'h0000_0001_0000_0000, d, rc, ov, dv, sok);
    n_cmp++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF || rc != 1 || dv) begin
      n_err++; $display("FAIL divuw_zero_low: got %h @%0d dv=%0b want ffffffffffffffff @1 dv=0", d, rc, dv); end
  endtask

  task automatic test_overflow;
    logic [63:0] d; int rc, ov; bit dv, sok;
    run_req(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, d, rc, ov, dv, sok);
    n_cmp++; if (d !== 64'h8000_0000_0000_0000 || rc != 1 || dv) begin
      n_err++; $display("FAIL div_ovf: got %h @%0d dv=%0b want 8000000000000000 @1 dv=0", d, rc, dv); end
    run_req(2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, d, rc, ov, dv, sok);
    n_cmp++; if (d !== 64'hFFFF_FFFF_8000_0000 || rc != 1 || dv) begin
      n_err++; $display("FAIL divw_ovf: got %h @%0d dv=%0b want ffffffff80000000 @1 dv=0", d, rc, dv); end
    run_req(2'b10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, d, rc, ov, dv, sok);
    n_cmp++; if (d !== 64'h0 || rc != 1 || dv) begin
      n_err++; $display("FAIL remw_ovf: got %h @%0d dv=%0b want 0 @1 dv=0", d, rc, dv); end
    run_req(2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, d, rc, ov, dv, sok);
    n_cmp++; if (d !== 64'h0 || !dv || rc != ov + 1) begin
      n_err++; $display("FAIL divu_no_ovf: got %h dv=%0b resp@%0d done@%0d want 0 dv=1 done+1", d, dv, rc, ov); end
  endtask

  task automatic test_back_to_back;
    bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_w = 1'b0;
    bus.req_src1 = 64'd7; bus.req_src2 = 64'd0;
    #1;
    n_cmp++; if ({bus.stall, bus.resp_valid} !== 2'b10) begin
      n_err++; $display("FAIL b2b_first_wait: got stall,resp=%b want 10", {bus.stall, bus.resp_valid}); end
    @(negedge clk); #1;
    n_cmp++; if ({bus.stall, bus.resp_valid} !== 2'b01 || bus.resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_err++; $display("FAIL b2b_first_resp: got %b %h want 01 ffffffffffffffff", {bus.stall, bus.resp_valid}, bus.resp_data); end
    bus.req_op = 2'b11; bus.req_src1 = 64'h1234;
    @(negedge clk); #1;
    n_cmp++; if ({bus.stall, bus.resp_valid} !== 2'b10) begin
      n_err++; $display("FAIL b2b_gap: got stall,resp=%b want 10", {bus.stall, bus.resp_valid}); end
    @(negedge clk); #1;
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 64'h1234) begin
      n_err++; $display("FAIL b2b_second_resp: got %b %h want 1 1234", bus.resp_valid, bus.resp_data); end
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush;
    logic [63:0] d; int rc, ov; bit dv, sok;
    int c; bit leaked;
    m_lat = 40;
    bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_w = 1'b0;
    bus.req_src1 = 64'd1000; bus.req_src2 = 64'd3;
    c = 0; #1;
    while (!bus.div_valid && c < 10) begin @(negedge clk); #1; c++; end
    n_cmp++; if (bus.div_valid !== 1'b1) begin
      n_err++; $display("FAIL flush_busy: got div_valid=%b want 1", bus.div_valid); end
    leaked = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); #1; if (bus.resp_valid) leaked = 1'b1; end
    bus.flush = 1'b1; #1;
    n_cmp++; if ({bus.div_flush, bus.div_valid, bus.resp_valid} !== 3'b100) begin
      n_err++; $display("FAIL flush_pulse: got flush,valid,resp=%b want 100", {bus.div_flush, bus.div_valid, bus.resp_valid}); end
    m_lat = 5;
    @(negedge clk); bus.flush = 1'b0;
    run_req(2'b01, 1'b0, 64'd100, 64'd7, d, rc, ov, dv, sok);
    n_cmp++; if (d !== 64'd14 || leaked) begin
      n_err++; $display("FAIL flush_next_divu: got %h leaked=%0b want 14 leaked=0", d, leaked); end
    n_cmp++; if (rc <= m_drain + 1 || !sok) begin
      n_err++; $display("FAIL flush_drain_wait: got resp@%0d stall_ok=%0b want >%0d, 1", rc, sok, m_drain + 1); end
    m_lat = 6;
  endtask

  task automatic test_flush_vs_done;
    int c; bit seen;
    m_lat = 3;
    bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_w = 1'b0;
    bus.req_src1 = 64'd50; bus.req_src2 = 64'd5;
    c = 0; #1;
    while (!bus.div_out_valid && c < 30) begin @(negedge clk); #1; c++; end
    bus.flush = 1'b1; #1;
    seen = bus.resp_valid;
    @(negedge clk); bus.flush = 1'b0; bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin #1; if (bus.resp_valid) seen = 1'b1; @(negedge clk); end
    n_cmp++; if (c >= 30 || seen) begin
      n_err++; $display("FAIL flush_on_done: got done_wait=%0d resp_seen=%0b want <30, 0", c, seen); end
    m_lat = 6;
  endtask

  task automatic test_reset_mid;
    logic [63:0] d; int rc, ov; bit dv, sok;
    m_lat = 30;
    bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_w = 1'b0;
    bus.req_src1 = 64'd100; bus.req_src2 = 64'd3;
    repeat (6) @(negedge clk);
    reset = 1'b1; bus.req_valid = 1'b0;
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++; if ({bus.stall, bus.resp_valid, bus.div_valid} !== 3'b000 || bus.resp_data !== 64'h0) begin
      n_err++; $display("FAIL reset_mid_idle: got %b %h want 000 0", {bus.stall, bus.resp_valid, bus.div_valid}, bus.resp_data); end
    m_lat = 4;
    @(negedge clk);
    run_req(2'b01, 1'b0, 64'd9, 64'd3, d, rc, ov, dv, sok);
    n_cmp++; if (d !== 64'd3 || rc != ov + 1) begin
      n_err++; $display("FAIL reset_mid_divu: got %h resp@%0d done@%0d want 3 done+1", d, rc, ov); end
  endtask

  initial begin
    reset = 1'b1; bus.flush = 1'b0; bus.req_valid = 1'b0; bus.req_op = 2'b00;
    bus.req_w = 1'b0; bus.req_src1 = '0; bus.req_src2 = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_div_signed;
    test_w_forms;
    test_div_zero;
    test_overflow;
    test_back_to_back;
    test_flush;
    test_flush_vs_done;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
